// File: rtl/mem_seg.sv
// MEM pipeline segment: data-memory loads/stores with configurable wait states,
// branch/jump redirect generation and WB-facing pipeline registers.
module mem_seg #(
  parameter int DEPTH   = 256,
  parameter int AW      = 8,
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IRi,
  input  logic        condi,
  input  logic [31:0] ALUi,
  input  logic [31:0] Bi,
  output logic        stall,
  output logic [31:0] IRo,
  output logic [31:0] ALUo,
  output logic [31:0] LMDo,
  output logic        br_take,
  output logic [31:0] br_target,
  output logic        mis_err
);

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_J   = 6'h02;

  localparam logic S_IDLE = 1'b0;
  localparam logic S_WAIT = 1'b1;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  logic              state;
  logic [3:0]        cnt;
  logic [31:0]       mem [DEPTH];

  logic [5:0]        op;
  logic [AW-1:0]     idx;
  logic [1:0]        lane;
  logic              is_lw, is_lb, is_lbu, is_sw, is_sb;
  logic              is_load, is_store, is_mem, take;
  logic              misaligned, commit, wr_en;
  logic [31:0]       rd_word, load_data;
  logic [7:0]        rd_byte;
  logic              unused;

  assign op     = IRi[31:26];
  assign idx    = ALUi[AW+1:2];
  assign lane   = ALUi[1:0];
  assign unused = ^{IRi[25:0], ALUi[31:AW+2]};

  assign is_lw    = (op == OP_LW);
  assign is_lb    = (op == OP_LB);
  assign is_lbu   = (op == OP_LBU);
  assign is_sw    = (op == OP_SW);
  assign is_sb    = (op == OP_SB);
  assign is_load  = is_lw | is_lb | is_lbu;
  assign is_store = is_sw | is_sb;
  assign is_mem   = is_load | is_store;
  assign take     = (((op == OP_BEQ) | (op == OP_BNE)) & condi) | (op == OP_J);

  assign misaligned = (is_lw | is_sw) & (lane != 2'b00);

  // Commit happens on the edge ending the last wait cycle (or immediately).
  always_comb begin
    commit = 1'b0;
    if (state == S_IDLE) commit = !is_mem || (MEM_LAT == 0);
    else                 commit = (cnt == '0);
  end

  assign stall = !commit;
  assign wr_en = commit & is_store & !misaligned & !rst;

  assign rd_word = mem[idx];

  always_comb begin
    rd_byte = rd_word[7:0];
    case (lane)
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      2'd3:    rd_byte = rd_word[31:24];
      default: rd_byte = rd_word[7:0];
    endcase
  end

  always_comb begin
    load_data = rd_word;
    if (is_lb)       load_data = {{24{rd_byte[7]}}, rd_byte};
    else if (is_lbu) load_data = {24'h0, rd_byte};
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (is_sw) begin
        mem[idx] <= Bi;
      end else begin
        case (lane)
          2'd1:    mem[idx][15:8]  <= Bi[7:0];
          2'd2:    mem[idx][23:16] <= Bi[7:0];
          2'd3:    mem[idx][31:24] <= Bi[7:0];
          default: mem[idx][7:0]   <= Bi[7:0];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      IRo       <= '0;
      ALUo      <= '0;
      LMDo      <= '0;
      br_take   <= 1'b0;
      br_target <= '0;
      mis_err   <= 1'b0;
    end else begin
      if (state == S_IDLE) begin
        if (is_mem && (MEM_LAT != 0)) begin
          state <= S_WAIT;
          cnt   <= LAT_M1;
        end
      end else begin
        if (cnt != '0) cnt <= cnt - 4'd1;
        else           state <= S_IDLE;
      end

      if (commit) begin
        IRo       <= IRi;
        ALUo      <= ALUi;
        br_take   <= take;
        br_target <= take ? ALUi : '0;
        mis_err   <= misaligned;
        if (misaligned)   LMDo <= '0;
        else if (is_load) LMDo <= load_data;
      end else begin
        IRo       <= '0;
        br_take   <= 1'b0;
        br_target <= '0;
        mis_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_seg.sv
// Directed self-checking bench for mem_seg: MEM_LAT=2 main instance plus a
// MEM_LAT=0 instance for the single-cycle stream.
module tb_mem_seg;

  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] ADD  = 32'h0085_1020;
  localparam logic [31:0] LW   = 32'h8C00_0001;
  localparam logic [31:0] LB   = 32'h8000_0002;
  localparam logic [31:0] LBU  = 32'h9000_0003;
  localparam logic [31:0] SW   = 32'hAC00_0004;
  localparam logic [31:0] SB   = 32'hA000_0005;
  localparam logic [31:0] BEQ  = 32'h1000_0006;
  localparam logic [31:0] BNE  = 32'h1400_0007;
  localparam logic [31:0] JMP  = 32'h0800_0008;
  localparam logic [31:0] ADDI = 32'h2000_0009;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IRi, ALUi, Bi;
  logic        condi;
  logic        stall, br_take, mis_err;
  logic [31:0] IRo, ALUo, LMDo, br_target;

  logic [31:0] IR0i, ALU0i, B0i;
  logic        cond0i;
  logic        stall0, br_take0, mis_err0;
  logic [31:0] IR0o, ALU0o, LMD0o, br_target0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_seg #(.DEPTH(256), .AW(8), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst), .IRi(IRi), .condi(condi), .ALUi(ALUi), .Bi(Bi),
    .stall(stall), .IRo(IRo), .ALUo(ALUo), .LMDo(LMDo),
    .br_take(br_take), .br_target(br_target), .mis_err(mis_err)
  );

  mem_seg #(.DEPTH(256), .AW(8), .MEM_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .IRi(IR0i), .condi(cond0i), .ALUi(ALU0i), .Bi(B0i),
    .stall(stall0), .IRo(IR0o), .ALUo(ALU0o), .LMDo(LMD0o),
    .br_take(br_take0), .br_target(br_target0), .mis_err(mis_err0)
  );

  typedef struct {
    logic [31:0] ir;
    logic        cond;
    logic [31:0] alu;
    logic        take;
    logic [31:0] target;
  } vec_t;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] alu;
    logic [31:0] b;
    logic        chk_lmd;
    logic [31:0] lmd;
  } svec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents one op, checks stall for nstall cycles (and bubbles), returns
  // 1 time unit after the commit edge with outputs valid.
  task automatic issue(input logic [31:0] ir, input logic c, input logic [31:0] a,
                       input logic [31:0] b, input int nstall);
    IRi = ir; condi = c; ALUi = a; Bi = b;
    #1;
    for (int i = 0; i < nstall; i++) begin
      chk("stall_high", {31'b0, stall}, 32'd1);
      if (i > 0) begin
        chk("bubble_IRo", IRo, 32'h0);
        chk("bubble_br_take", {31'b0, br_take}, 32'd0);
      end
      @(posedge clk); #2;
    end
    chk("stall_low", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
  endtask

  vec_t  vecs[8];
  svec_t svecs[7];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{BEQ,  1'b1, 32'h0000_0040, 1'b1, 32'h0000_0040};
    vecs[1] = '{BNE,  1'b0, 32'h0000_0080, 1'b0, 32'h0};
    vecs[2] = '{JMP,  1'b0, 32'h0000_0100, 1'b1, 32'h0000_0100};
    vecs[3] = '{BEQ,  1'b0, 32'h0000_0044, 1'b0, 32'h0};
    vecs[4] = '{BNE,  1'b1, 32'h0000_0084, 1'b1, 32'h0000_0084};
    vecs[5] = '{ADD,  1'b1, 32'h1234_5678, 1'b0, 32'h0};
    vecs[6] = '{NOP,  1'b0, 32'h0000_0000, 1'b0, 32'h0};
    vecs[7] = '{ADDI, 1'b1, 32'h0000_0200, 1'b0, 32'h0};

    svecs[0] = '{ADD, 32'h0000_0020, 32'h0,         1'b0, 32'h0};
    svecs[1] = '{SW,  32'h0000_0020, 32'h0000_0077, 1'b0, 32'h0};
    svecs[2] = '{LW,  32'h0000_0020, 32'h0,         1'b1, 32'h0000_0077};
    svecs[3] = '{ADD, 32'h0000_0030, 32'h0,         1'b0, 32'h0};
    svecs[4] = '{SW,  32'h0000_0024, 32'h0000_0088, 1'b0, 32'h0};
    svecs[5] = '{LW,  32'h0000_0024, 32'h0,         1'b1, 32'h0000_0088};
    svecs[6] = '{NOP, 32'h0,         32'h0,         1'b0, 32'h0};

    rst = 1'b1;
    IRi = '0; condi = 1'b0; ALUi = '0; Bi = '0;
    IR0i = '0; cond0i = 1'b0; ALU0i = '0; B0i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_IRo", IRo, 32'h0);
    chk("rst_ALUo", ALUo, 32'h0);
    chk("rst_LMDo", LMDo, 32'h0);
    chk("rst_br_target", br_target, 32'h0);
    chk("rst_br_take", {31'b0, br_take}, 32'd0);
    chk("rst_mis_err", {31'b0, mis_err}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single-cycle ops from the vector table.
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].ir, vecs[i].cond, vecs[i].alu, 32'h0, 0);
      chk("vec_IRo", IRo, vecs[i].ir);
      chk("vec_ALUo", ALUo, vecs[i].alu);
      chk("vec_br_take", {31'b0, br_take}, {31'b0, vecs[i].take});
      if (vecs[i].take) chk("vec_br_target", br_target, vecs[i].target);
      chk("vec_mis_err", {31'b0, mis_err}, 32'd0);
    end

    // Store then load, read-after-write.
    issue(SW, 1'b0, 32'h10, 32'hDEAD_BEEF, 2);
    chk("sw_IRo", IRo, SW);
    issue(LW, 1'b0, 32'h10, 32'h0, 2);
    chk("lw_IRo", IRo, LW);
    chk("lw_ALUo", ALUo, 32'h10);
    chk("lw_LMDo", LMDo, 32'hDEAD_BEEF);

    // Byte store into one lane, then byte loads.
    issue(SW, 1'b0, 32'h10, 32'h1122_3344, 2);
    issue(SB, 1'b0, 32'h13, 32'h0000_00A5, 2);
    issue(LW, 1'b0, 32'h10, 32'h0, 2);
    chk("sb_word", LMDo, 32'hA522_3344);
    issue(LB, 1'b0, 32'h13, 32'h0, 2);
    chk("lb_neg", LMDo, 32'hFFFF_FFA5);
    issue(LBU, 1'b0, 32'h13, 32'h0, 2);
    chk("lbu", LMDo, 32'h0000_00A5);
    issue(LB, 1'b0, 32'h10, 32'h0, 2);
    chk("lb_lane0", LMDo, 32'h0000_0044);
    issue(LB, 1'b0, 32'h11, 32'h0, 2);
    chk("lb_lane1", LMDo, 32'h0000_0033);
    issue(LBU, 1'b0, 32'h12, 32'h0, 2);
    chk("lbu_lane2", LMDo, 32'h0000_0022);

    // Misaligned load.
    issue(LW, 1'b0, 32'h12, 32'h0, 2);
    chk("mis_lw_err", {31'b0, mis_err}, 32'd1);
    chk("mis_lw_LMDo", LMDo, 32'h0);
    chk("mis_lw_IRo", IRo, LW);
    chk("mis_lw_ALUo", ALUo, 32'h12);
    issue(NOP, 1'b0, 32'h0, 32'h0, 0);
    chk("mis_err_pulse", {31'b0, mis_err}, 32'd0);
    issue(LW, 1'b0, 32'h10, 32'h0, 2);
    chk("mis_lw_mem", LMDo, 32'hA522_3344);

    // Misaligned store and address wrap.
    issue(SW, 1'b0, 32'h0, 32'h1234_5678, 2);
    issue(SW, 1'b0, 32'h401, 32'h0000_0001, 2);
    chk("mis_sw_err", {31'b0, mis_err}, 32'd1);
    issue(LW, 1'b0, 32'h0, 32'h0, 2);
    chk("mis_sw_nowrite", LMDo, 32'h1234_5678);
    chk("lw_mis_clear", {31'b0, mis_err}, 32'd0);
    issue(SW, 1'b0, 32'h404, 32'hCAFE_F00D, 2);
    issue(LW, 1'b0, 32'h4, 32'h0, 2);
    chk("wrap_lw", LMDo, 32'hCAFE_F00D);

    // Reset on the commit cycle of a store aborts it.
    IRi = SW; condi = 1'b0; ALUi = 32'h10; Bi = 32'h9999_9999;
    #1;
    chk("abort_stall0", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    chk("abort_stall1", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    IRi = NOP; ALUi = '0; Bi = '0;
    #1;
    chk("abort_IRo", IRo, 32'h0);
    chk("abort_ALUo", ALUo, 32'h0);
    chk("abort_LMDo", LMDo, 32'h0);
    chk("abort_br_take", {31'b0, br_take}, 32'd0);
    chk("abort_mis_err", {31'b0, mis_err}, 32'd0);
    chk("abort_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    issue(LW, 1'b0, 32'h10, 32'h0, 2);
    chk("abort_old_data", LMDo, 32'hA522_3344);
    IRi = NOP; ALUi = '0;

    // Single-cycle memory stream.
    for (int i = 0; i < 7; i++) begin
      IR0i = svecs[i].ir; ALU0i = svecs[i].alu; B0i = svecs[i].b;
      #1;
      chk("lat0_stall", {31'b0, stall0}, 32'd0);
      @(posedge clk); #1;
      chk("lat0_IRo", IR0o, svecs[i].ir);
      if (svecs[i].chk_lmd) chk("lat0_LMDo", LMD0o, svecs[i].lmd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
